pht_access_sched: RTL

- Schedules all accesses to the single-port pattern history table (PHT) RAM of 2-bit saturating counters used by the branch predictor.
- Arbitrates fetch-stage lookups (predict) against resolution-stage updates (result write-back), which need a read-modify-write.
- Buffers pending updates in a small queue and sweeps the whole table to the initial value after reset.
- Sits between the fetch/ID stage, the branch-resolve logic and the PHT RAM macro.

---
 rtl/pht_access_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pht_access_sched.sv
// Access scheduler for the single-port PHT RAM: sweeps the table after reset,
// then arbitrates fetch lookups against queued read-modify-write counter updates.
module pht_access_sched #(
   parameter int               ADDRESS = 12,
   parameter int               WIDTH   = 2,
   parameter logic [WIDTH-1:0] INITIAL = 2'b01,
   parameter int               QDEPTH  = 4,
   parameter int               STARVE  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lk_req,
   input  logic [ADDRESS-1:0] lk_index,
   output logic               lk_gnt,
   output logic               lk_valid,
   output logic               lk_taken,
   input  logic               up_req,
   input  logic [ADDRESS-1:0] up_index,
   input  logic               up_result,
   output logic               up_ready,
   output logic               init_busy,
   output logic               ram_en,
   output logic               ram_we,
   output logic [ADDRESS-1:0] ram_addr,
   output logic [WIDTH-1:0]   ram_wdata,
   input  logic [WIDTH-1:0]   ram_rdata
);

   localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int SW = $clog2(STARVE + 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_UP_WR} state_t;

   typedef struct packed {
      logic [ADDRESS-1:0] index;
      logic               result;
   } upd_t;

   state_t             state, state_nxt;
   logic [ADDRESS-1:0] init_ptr;
   logic [SW-1:0]      starve_cnt;
   upd_t               queue [QDEPTH];
   upd_t               head_ent;
   logic [QW-1:0]      head, tail;
   logic [QW:0]        count, count_nxt;
   logic               q_empty, q_full, force_up;
   logic               push, pop, grant, up_rd;
   logic               en_c, we_c;
   logic [ADDRESS-1:0] addr_c;
   logic [WIDTH-1:0]   wdata_c;

   function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] v, input logic taken);
      if (taken) return (&v) ? v : v + 1'b1;
      else       return (v == '0) ? v : v - 1'b1;
   endfunction

   assign head_ent = queue[head];
   assign q_empty  = (count == '0);
   assign q_full   = (count == (QW+1)'(QDEPTH));
   assign force_up = q_full || (starve_cnt == SW'(STARVE));
   assign push     = up_req && up_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= state_nxt;
   end

   // Next state; the update read is issued from IDLE, so UP_WR always follows it
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (init_ptr == {ADDRESS{1'b1}}) state_nxt = S_IDLE;
         S_IDLE:  if (!q_empty && (force_up || !lk_req)) state_nxt = S_UP_WR;
         S_UP_WR: state_nxt = S_IDLE;
         default: state_nxt = S_INIT;
      endcase
   end

   // Outputs / RAM strobes
   always_comb begin
      grant   = 1'b0;
      up_rd   = 1'b0;
      pop     = 1'b0;
      en_c    = 1'b0;
      we_c    = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
      case (state)
         S_INIT: begin
            en_c    = 1'b1;
            we_c    = 1'b1;
            addr_c  = init_ptr;
            wdata_c = INITIAL;
         end
         S_IDLE: begin
            if (!q_empty && force_up) begin
               up_rd = 1'b1;
            end else if (lk_req) begin
               grant  = 1'b1;
               en_c   = 1'b1;
               addr_c = lk_index;
            end else if (!q_empty) begin
               up_rd = 1'b1;
            end
            if (up_rd) begin
               en_c   = 1'b1;
               addr_c = head_ent.index;
            end
         end
         S_UP_WR: begin
            pop     = 1'b1;
            en_c    = 1'b1;
            we_c    = 1'b1;
            addr_c  = head_ent.index;
            wdata_c = sat(ram_rdata, head_ent.result);
         end
         default: ;
      endcase
   end

   // Strobes are held off while reset is asserted, even though state reads INIT
   assign lk_gnt    = rst_n & grant;
   assign ram_en    = rst_n & en_c;
   assign ram_we    = rst_n & we_c;
   assign ram_addr  = addr_c;
   assign ram_wdata = wdata_c;
   assign lk_taken  = ram_rdata[WIDTH-1] & lk_valid;
   assign init_busy = (state == S_INIT);

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_ptr   <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         starve_cnt <= '0;
         lk_valid   <= 1'b0;
         up_ready   <= 1'b0;
      end else begin
         if (state == S_INIT) init_ptr <= init_ptr + 1'b1;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count    <= count_nxt;
         lk_valid <= grant;
         up_ready <= (state_nxt != S_INIT) && (count_nxt < (QW+1)'(QDEPTH));
         if (pop)
            starve_cnt <= '0;
         else if (grant && !q_empty && starve_cnt != SW'(STARVE))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Queue payload needs no reset; pointers and count define what is live
   always_ff @(posedge clk) begin
      if (push) queue[tail] <= '{index: up_index, result: up_result};
   end

endmodule
